// File: rtl/kyber_bram_pkg.sv
// Shared constants and FSM state types for the host-side Kyber BRAM bridge.
// Line offsets/counts describe the layout of the core's input/output BRAMs.
package kyber_bram_pkg;
  localparam int LANES = 4;

  localparam int PK_OFF   = 0;
  localparam int M_OFF    = 50;
  localparam int COIN_OFF = 52;
  localparam int SK_OFF   = 54;
  localparam int C_OFF    = 102;

  localparam int PK_LINES   = 50;
  localparam int M_LINES    = 2;
  localparam int COIN_LINES = 2;
  localparam int SK_LINES   = 48;
  localparam int C_LINES    = 48;

  typedef enum logic {L_IDLE, L_FILL} load_state_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT, D_EMIT} drain_state_t;
endpackage

// File: rtl/kyber_host_bram_bridge_if.sv
// Host stream + BRAM port bundle. slave = bridge side, master = host/BRAM side.
interface kyber_host_bram_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
);
  logic                ld_start;
  logic [ADDR_W-1:0]   ld_base;
  logic [ADDR_W-1:0]   ld_lines;
  logic [WORD_W-1:0]   ld_data;
  logic                ld_valid;
  logic                ld_ready;
  logic                ld_done;
  logic [ADDR_W-1:0]   addr_wr;
  logic                en_wr;
  logic [LINE_W/8-1:0] we_wr;
  logic [LINE_W-1:0]   wrdata_wr;

  logic                dr_start;
  logic [ADDR_W-1:0]   dr_base;
  logic [ADDR_W-1:0]   dr_lines;
  logic [WORD_W-1:0]   dr_data;
  logic                dr_valid;
  logic                dr_ready;
  logic                dr_done;
  logic [ADDR_W-1:0]   addr_rd;
  logic                en_rd;
  logic [LINE_W-1:0]   rddata_rd;

  modport slave (
    input  ld_start, ld_base, ld_lines, ld_data, ld_valid,
    output ld_ready, ld_done, addr_wr, en_wr, we_wr, wrdata_wr,
    input  dr_start, dr_base, dr_lines, dr_ready, rddata_rd,
    output dr_data, dr_valid, dr_done, addr_rd, en_rd
  );

  modport master (
    output ld_start, ld_base, ld_lines, ld_data, ld_valid,
    input  ld_ready, ld_done, addr_wr, en_wr, we_wr, wrdata_wr,
    output dr_start, dr_base, dr_lines, dr_ready, rddata_rd,
    input  dr_data, dr_valid, dr_done, addr_rd, en_rd
  );
endinterface

// File: rtl/kyber_bram_drain.sv
// Drain channel: reads output-BRAM lines and emits them as a word stream,
// low lane first, holding each word until the consumer takes it.
module kyber_bram_drain
  import kyber_bram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] lines,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              done,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              en_rd,
  input  logic [LINE_W-1:0] rddata_rd
);
  localparam int NL = LINE_W / WORD_W;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  drain_state_t state, state_nx;
  logic [ADDR_W-1:0] base_q, lines_q, line_q;
  logic [LW-1:0] lane_q;
  logic [NL-1:0][WORD_W-1:0] line_buf;
  // vld_pipe[k] marks the k-th cycle after the read request; [RD_LAT] is the capture cycle
  logic [RD_LAT:1] vld_pipe;
  logic fire, lane_last, line_last;

  assign lane_last = (lane_q == LW'(NL - 1));
  assign line_last = (line_q == lines_q - ADDR_W'(1));
  assign fire      = valid & ready;

  always_comb begin
    state_nx = state;
    valid    = 1'b0;
    en_rd    = 1'b0;
    addr_rd  = '0;
    data     = '0;
    case (state)
      D_IDLE: if (start && lines != '0) state_nx = D_REQ;
      D_REQ: begin
        en_rd    = 1'b1;
        addr_rd  = base_q + line_q;
        state_nx = D_WAIT;
      end
      D_WAIT: if (vld_pipe[RD_LAT]) state_nx = D_EMIT;
      D_EMIT: begin
        valid = 1'b1;
        data  = line_buf[lane_q];
        if (ready && lane_last) state_nx = line_last ? D_IDLE : D_REQ;
      end
      default: state_nx = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= D_IDLE;
      base_q   <= '0;
      lines_q  <= '0;
      line_q   <= '0;
      lane_q   <= '0;
      line_buf <= '0;
      vld_pipe <= '0;
      done     <= 1'b0;
    end else begin
      state       <= state_nx;
      done        <= 1'b0;
      vld_pipe[1] <= en_rd;
      for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      if (state == D_IDLE && start) begin
        base_q  <= base;
        lines_q <= lines;
        line_q  <= '0;
        lane_q  <= '0;
        if (lines == '0) done <= 1'b1;
      end
      if (vld_pipe[RD_LAT]) line_buf <= rddata_rd;
      if (fire) begin
        lane_q <= lane_q + LW'(1);
        if (lane_last) begin
          line_q <= line_q + ADDR_W'(1);
          if (line_last) done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/kyber_host_bram_bridge.sv
// Host <-> Kyber BRAM bridge: packs 32-bit words into 128-bit input-BRAM line
// writes (load) and unpacks output-BRAM lines into words (drain, sub-module).
module kyber_host_bram_bridge
  import kyber_bram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32,
  parameter int RD_LAT = 1
) (
  input logic reg_clk,
  input logic reg_rst_n,
  kyber_host_bram_bridge_if.slave bus
);
  localparam int NL = LINE_W / WORD_W;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  load_state_t l_state, l_state_nx;
  logic [ADDR_W-1:0] l_base, l_lines, l_line;
  logic [LW-1:0] l_lane;
  logic [NL-1:0][WORD_W-1:0] l_buf, l_word;
  logic l_fire, l_lane_last, l_line_last, l_wr_last;

  assign l_fire      = bus.ld_valid & (l_state == L_FILL);
  assign l_lane_last = (l_lane == LW'(NL - 1));
  assign l_line_last = (l_line == l_lines - ADDR_W'(1));

  // Line being assembled with the incoming word merged into its lane
  for (genvar i = 0; i < NL; i++) begin : g_lane
    assign l_word[i] = (l_lane == LW'(i)) ? bus.ld_data : l_buf[i];
  end

  always_comb begin
    l_state_nx   = l_state;
    bus.ld_ready = 1'b0;
    case (l_state)
      L_IDLE: if (bus.ld_start && bus.ld_lines != '0) l_state_nx = L_FILL;
      L_FILL: begin
        bus.ld_ready = 1'b1;
        if (l_fire && l_lane_last && l_line_last) l_state_nx = L_IDLE;
      end
      default: l_state_nx = L_IDLE;
    endcase
  end

  // Write port is registered; done trails the final write by one cycle
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      l_state       <= L_IDLE;
      l_base        <= '0;
      l_lines       <= '0;
      l_line        <= '0;
      l_lane        <= '0;
      l_buf         <= '0;
      l_wr_last     <= 1'b0;
      bus.en_wr     <= 1'b0;
      bus.we_wr     <= '0;
      bus.addr_wr   <= '0;
      bus.wrdata_wr <= '0;
      bus.ld_done   <= 1'b0;
    end else begin
      l_state     <= l_state_nx;
      bus.en_wr   <= 1'b0;
      bus.we_wr   <= '0;
      l_wr_last   <= 1'b0;
      bus.ld_done <= l_wr_last;
      if (l_state == L_IDLE && bus.ld_start) begin
        l_base  <= bus.ld_base;
        l_lines <= bus.ld_lines;
        l_line  <= '0;
        l_lane  <= '0;
        if (bus.ld_lines == '0) bus.ld_done <= 1'b1;
      end
      if (l_fire) begin
        l_buf  <= l_word;
        l_lane <= l_lane + LW'(1);
        if (l_lane_last) begin
          bus.en_wr     <= 1'b1;
          bus.we_wr     <= '1;
          bus.addr_wr   <= l_base + l_line;
          bus.wrdata_wr <= l_word;
          l_line        <= l_line + ADDR_W'(1);
          l_wr_last     <= l_line_last;
        end
      end
    end
  end

  kyber_bram_drain #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)
  ) u_drain (
    .clk      (reg_clk),
    .rst_n    (reg_rst_n),
    .start    (bus.dr_start),
    .base     (bus.dr_base),
    .lines    (bus.dr_lines),
    .data     (bus.dr_data),
    .valid    (bus.dr_valid),
    .ready    (bus.dr_ready),
    .done     (bus.dr_done),
    .addr_rd  (bus.addr_rd),
    .en_rd    (bus.en_rd),
    .rddata_rd(bus.rddata_rd)
  );
endmodule

// File: tb/tb_kyber_host_bram_bridge.sv
// Randomized self-checking bench for kyber_host_bram_bridge with BRAM models
// and a line/word reference model derived from the lane-packing rules.
module tb_kyber_host_bram_bridge;
  import kyber_bram_pkg::*;

  localparam int ADDR_W = 8;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kyber_host_bram_bridge_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W)) bus ();

  kyber_host_bram_bridge #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)
  ) dut (
    .reg_clk  (clk),
    .reg_rst_n(rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [LINE_W-1:0] omem [DEPTH];
  logic [WORD_W-1:0] wq[$];

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [LINE_W-1:0] wr_data_q[$];
  int                wr_cyc_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  logic [WORD_W-1:0] dr_q[$];
  int                dr_cyc_q[$];
  int ld_done_n = 0, ld_done_cyc = 0, dr_done_n = 0, dr_done_cyc = 0, we_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output BRAM with RD_LAT=1
  always @(posedge clk) if (bus.en_rd) bus.rddata_rd <= omem[bus.addr_rd];

  always @(negedge clk) begin
    if (bus.en_wr) begin
      wr_addr_q.push_back(bus.addr_wr);
      wr_data_q.push_back(bus.wrdata_wr);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.en_wr ? (bus.we_wr !== '1) : (bus.we_wr !== '0)) we_err <= we_err + 1;
    if (bus.ld_done) begin ld_done_n <= ld_done_n + 1; ld_done_cyc <= cyc; end
    if (bus.en_rd) rd_addr_q.push_back(bus.addr_rd);
    if (bus.dr_valid && bus.dr_ready) begin dr_q.push_back(bus.dr_data); dr_cyc_q.push_back(cyc); end
    if (bus.dr_done) begin dr_done_n <= dr_done_n + 1; dr_done_cyc <= cyc; end
  end

  // Reference model: word k of a line sits at bits [32k +: 32]
  function automatic logic [LINE_W-1:0] pack_line(input int i);
    logic [LINE_W-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++) v[WORD_W*j +: WORD_W] = wq[LANES*i + j];
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] dr_word(input int b, input int k);
    logic [LINE_W-1:0] l;
    l = omem[ADDR_W'(b + k / LANES)];
    return l[WORD_W*(k % LANES) +: WORD_W];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); dr_q.delete(); dr_cyc_q.delete();
  endtask

  task automatic start_load(input int b, input int l, output int s);
    tick();
    bus.ld_start = 1'b1; bus.ld_base = ADDR_W'(b); bus.ld_lines = ADDR_W'(l);
    s = cyc;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic start_drain(input int b, input int l, output int s);
    tick();
    bus.dr_start = 1'b1; bus.dr_base = ADDR_W'(b); bus.dr_lines = ADDR_W'(l);
    s = cyc;
    tick();
    bus.dr_start = 1'b0;
  endtask

  task automatic drive_load(input int n, input int gap_pct);
    int i = 0;
    for (int g = 0; g < 4000 && i < n; g++) begin
      bus.ld_valid = ($urandom_range(99) >= gap_pct);
      bus.ld_data  = wq[i];
      @(negedge clk);
      if (bus.ld_valid && bus.ld_ready) i++;
      tick();
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic wait_ld_done(input int d0);
    for (int k = 0; k < 200 && ld_done_n == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_dr_done(input int d0);
    for (int k = 0; k < 400 && dr_done_n == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ld_start = 1'b1; bus.ld_lines = 8'd3; bus.ld_valid = 1'b1; bus.dr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.ld_ready, bus.ld_done, bus.en_wr, bus.we_wr} !== '0) begin
      n_fail++; $display("FAIL reset_ld: got rdy=%b done=%b en=%b we=%h want 0", bus.ld_ready, bus.ld_done, bus.en_wr, bus.we_wr);
    end
    n_chk++;
    if ({bus.addr_wr, bus.wrdata_wr} !== '0) begin
      n_fail++; $display("FAIL reset_wr_bus: got addr=%h data=%h want 0", bus.addr_wr, bus.wrdata_wr);
    end
    n_chk++;
    if ({bus.dr_valid, bus.dr_done, bus.dr_data, bus.en_rd, bus.addr_rd} !== '0) begin
      n_fail++; $display("FAIL reset_dr: got vld=%b done=%b data=%h en=%b addr=%h want 0", bus.dr_valid, bus.dr_done, bus.dr_data, bus.en_rd, bus.addr_rd);
    end
    bus.ld_start = 1'b0; bus.ld_lines = '0; bus.ld_valid = 1'b0; bus.dr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.ld_ready !== 1'b0 || bus.ld_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got rdy=%b done=%b want 0 0", bus.ld_ready, bus.ld_done);
    end
  endtask

  task automatic test_load_coin();
    int s, d0, e0;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(WORD_W'(i));
    clear_q(); d0 = ld_done_n; e0 = we_err;
    start_load(COIN_OFF, COIN_LINES, s);
    drive_load(8, 0);
    wait_ld_done(d0);
    n_chk++;
    if (wr_addr_q.size() != 2) begin
      n_fail++; $display("FAIL coin_count: got %0d writes want 2", wr_addr_q.size());
    end
    n_chk++;
    if (wr_addr_q.size() < 1 || wr_addr_q[0] !== 8'd52 || wr_data_q[0] !== 128'h00000003_00000002_00000001_00000000) begin
      n_fail++; $display("FAIL coin_line0: got %p / %p want addr 52 data 00000003_00000002_00000001_00000000", wr_addr_q, wr_data_q);
    end
    n_chk++;
    if (wr_addr_q.size() < 2 || wr_addr_q[1] !== 8'd53 || wr_data_q[1] !== 128'h00000007_00000006_00000005_00000004) begin
      n_fail++; $display("FAIL coin_line1: got %p / %p want addr 53 data 00000007_00000006_00000005_00000004", wr_addr_q, wr_data_q);
    end
    n_chk++;
    if (wr_cyc_q.size() < 2 || wr_cyc_q[1] != s + 9) begin
      n_fail++; $display("FAIL coin_throughput: got write cycles %p want second at %0d", wr_cyc_q, s + 9);
    end
    n_chk++;
    if (ld_done_n != d0 + 1 || ld_done_cyc != s + 10) begin
      n_fail++; $display("FAIL coin_done: got %0d pulses at cycle %0d want 1 at %0d", ld_done_n - d0, ld_done_cyc, s + 10);
    end
    n_chk++;
    if (we_err != e0) begin
      n_fail++; $display("FAIL coin_we: got %0d bad we_wr cycles want 0", we_err - e0);
    end
  endtask

  task automatic test_load_gaps();
    int s, d0;
    wq.delete();
    for (int i = 0; i < PK_LINES * LANES; i++) wq.push_back($urandom);
    clear_q(); d0 = ld_done_n;
    start_load(PK_OFF, PK_LINES, s);
    drive_load(PK_LINES * LANES, 40);
    wait_ld_done(d0);
    n_chk++;
    if (wr_addr_q.size() != PK_LINES) begin
      n_fail++; $display("FAIL gaps_count: got %0d writes want %0d", wr_addr_q.size(), PK_LINES);
    end
    for (int i = 0; i < PK_LINES; i++) begin
      n_chk++;
      if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(PK_OFF + i) || wr_data_q[i] !== pack_line(i)) begin
        n_fail++; $display("FAIL gaps_line%0d: want addr %0d data %h", i, PK_OFF + i, pack_line(i));
      end
    end
    n_chk++;
    if (ld_done_n != d0 + 1) begin
      n_fail++; $display("FAIL gaps_done: got %0d pulses want 1", ld_done_n - d0);
    end
  endtask

  task automatic test_drain();
    int s, d0, fv;
    clear_q(); d0 = dr_done_n; fv = -1;
    bus.dr_ready = 1'b1;
    start_drain(C_OFF, 2, s);
    for (int k = 0; k < 20 && fv < 0; k++) begin
      @(negedge clk);
      if (bus.dr_valid) fv = cyc;
    end
    n_chk++;
    if (fv - s != 2 + RD_LAT) begin
      n_fail++; $display("FAIL drain_latency: got %0d cycles want %0d", fv - s, 2 + RD_LAT);
    end
    wait_dr_done(d0);
    n_chk++;
    if (dr_q.size() != 8) begin
      n_fail++; $display("FAIL drain_count: got %0d words want 8", dr_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k >= dr_q.size() || dr_q[k] !== dr_word(C_OFF, k)) begin
        n_fail++; $display("FAIL drain_word%0d: want %h", k, dr_word(C_OFF, k));
      end
    end
    n_chk++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 8'd102 || rd_addr_q[1] !== 8'd103) begin
      n_fail++; $display("FAIL drain_reads: got %p want 102 103", rd_addr_q);
    end
    n_chk++;
    if (dr_done_n != d0 + 1 || dr_cyc_q.size() < 8 || dr_done_cyc != dr_cyc_q[7] + 1) begin
      n_fail++; $display("FAIL drain_done: got %0d pulses at cycle %0d want 1 after last handshake", dr_done_n - d0, dr_done_cyc);
    end
  endtask

  task automatic test_drain_backpressure();
    int s, d0, b, r0;
    logic [WORD_W-1:0] hold;
    logic stable;
    clear_q(); d0 = dr_done_n; b = $urandom_range(DEPTH - 1);
    bus.dr_ready = 1'b1;
    start_drain(b, 2, s);
    for (int k = 0; k < 50 && dr_q.size() < 2; k++) tick();
    bus.dr_ready = 1'b0;
    @(negedge clk);
    hold = bus.dr_data; r0 = rd_addr_q.size(); stable = bus.dr_valid;
    repeat (9) begin
      @(negedge clk);
      if (!bus.dr_valid || bus.dr_data !== hold) stable = 1'b0;
    end
    n_chk++;
    if (!stable || hold !== dr_word(b, 2)) begin
      n_fail++; $display("FAIL bp_stall_data: got %h stable=%b want %h stable", hold, stable, dr_word(b, 2));
    end
    n_chk++;
    if (rd_addr_q.size() != r0) begin
      n_fail++; $display("FAIL bp_stall_reads: got %0d extra reads want 0", rd_addr_q.size() - r0);
    end
    tick();
    bus.dr_ready = 1'b1;
    wait_dr_done(d0);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k >= dr_q.size() || dr_q[k] !== dr_word(b, k)) begin
        n_fail++; $display("FAIL bp_word%0d: want %h", k, dr_word(b, k));
      end
    end
  endtask

  task automatic test_wrap_zero();
    int s, d0, dd0, w0;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    clear_q(); d0 = ld_done_n;
    start_load(255, 2, s);
    drive_load(8, 25);
    wait_ld_done(d0);
    n_chk++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 8'd255 || wr_addr_q[1] !== 8'd0
        || wr_data_q[0] !== pack_line(0) || wr_data_q[1] !== pack_line(1)) begin
      n_fail++; $display("FAIL wrap_load: got addrs %p want 255 0 with packed data", wr_addr_q);
    end
    clear_q(); d0 = ld_done_n;
    start_load($urandom_range(DEPTH - 1), 0, s);
    repeat (4) @(negedge clk);
    n_chk++;
    if (ld_done_n != d0 + 1 || ld_done_cyc != s + 1 || wr_addr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_load: got %0d done at %0d, %0d writes want 1 at %0d, 0 writes", ld_done_n - d0, ld_done_cyc, wr_addr_q.size(), s + 1);
    end
    dd0 = dr_done_n; w0 = rd_addr_q.size();
    start_drain($urandom_range(DEPTH - 1), 0, s);
    repeat (4) @(negedge clk);
    n_chk++;
    if (dr_done_n != dd0 + 1 || dr_done_cyc != s + 1 || rd_addr_q.size() != w0 || dr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_drain: got %0d done at %0d, %0d reads want 1 at %0d, 0 reads", dr_done_n - dd0, dr_done_cyc, rd_addr_q.size() - w0, s + 1);
    end
  endtask

  task automatic test_concurrent();
    int bl, bd, d0, dd0, i;
    bl = $urandom_range(DEPTH - 1); bd = $urandom_range(DEPTH - 1);
    wq.delete();
    for (int k = 0; k < 12; k++) wq.push_back($urandom);
    clear_q(); d0 = ld_done_n; dd0 = dr_done_n;
    tick();
    bus.ld_start = 1'b1; bus.ld_base = ADDR_W'(bl); bus.ld_lines = 8'd3;
    bus.dr_start = 1'b1; bus.dr_base = ADDR_W'(bd); bus.dr_lines = 8'd3;
    tick();
    // Both channels are busy now: these starts must be ignored
    bus.ld_base = ADDR_W'(bl + 100); bus.ld_lines = 8'd7;
    bus.dr_base = ADDR_W'(bd + 50);  bus.dr_lines = 8'd9;
    tick();
    bus.ld_start = 1'b0; bus.dr_start = 1'b0;
    i = 0;
    for (int g = 0; g < 2000 && (ld_done_n == d0 || dr_done_n == dd0); g++) begin
      bus.ld_valid = (i < 12) && ($urandom_range(3) != 0);
      bus.ld_data  = (i < 12) ? wq[i] : '0;
      bus.dr_ready = $urandom_range(1);
      @(negedge clk);
      if (bus.ld_valid && bus.ld_ready) i++;
      tick();
    end
    bus.ld_valid = 1'b0; bus.dr_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (wr_addr_q.size() != 3) begin
      n_fail++; $display("FAIL conc_wr_count: got %0d writes want 3", wr_addr_q.size());
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (k >= wr_addr_q.size() || wr_addr_q[k] !== ADDR_W'(bl + k) || wr_data_q[k] !== pack_line(k)) begin
        n_fail++; $display("FAIL conc_line%0d: want addr %0d data %h", k, ADDR_W'(bl + k), pack_line(k));
      end
    end
    n_chk++;
    if (rd_addr_q.size() != 3 || rd_addr_q[0] !== ADDR_W'(bd) || rd_addr_q[2] !== ADDR_W'(bd + 2)) begin
      n_fail++; $display("FAIL conc_reads: got %p want %0d..%0d", rd_addr_q, bd, bd + 2);
    end
    for (int k = 0; k < 12; k++) begin
      n_chk++;
      if (k >= dr_q.size() || dr_q[k] !== dr_word(bd, k)) begin
        n_fail++; $display("FAIL conc_word%0d: want %h", k, dr_word(bd, k));
      end
    end
    n_chk++;
    if (ld_done_n != d0 + 1 || dr_done_n != dd0 + 1) begin
      n_fail++; $display("FAIL conc_done: got ld %0d dr %0d pulses want 1 1", ld_done_n - d0, dr_done_n - dd0);
    end
  endtask

  task automatic test_reset_mid_load();
    int s, d0, bl;
    bl = $urandom_range(DEPTH - 1);
    wq.delete();
    for (int k = 0; k < 8; k++) wq.push_back($urandom);
    clear_q(); d0 = ld_done_n;
    start_load(bl, 2, s);
    drive_load(5, 0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.ld_ready, bus.ld_done, bus.en_wr, bus.we_wr, bus.addr_wr, bus.wrdata_wr} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got rdy=%b en=%b addr=%h want all 0", bus.ld_ready, bus.en_wr, bus.addr_wr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== ADDR_W'(bl) || wr_data_q[0] !== pack_line(0) || ld_done_n != d0) begin
      n_fail++; $display("FAIL midrst_abandon: got %0d writes, %0d done want 1 write, 0 done", wr_addr_q.size(), ld_done_n - d0);
    end
    wq.delete();
    for (int k = 0; k < 8; k++) wq.push_back($urandom);
    clear_q(); d0 = ld_done_n;
    start_load(bl, 2, s);
    drive_load(8, 20);
    wait_ld_done(d0);
    n_chk++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== ADDR_W'(bl) || wr_addr_q[1] !== ADDR_W'(bl + 1)
        || wr_data_q[0] !== pack_line(0) || wr_data_q[1] !== pack_line(1) || ld_done_n != d0 + 1) begin
      n_fail++; $display("FAIL midrst_reload: got %0d writes addrs %p, %0d done want 2 writes, 1 done", wr_addr_q.size(), wr_addr_q, ld_done_n - d0);
    end
  endtask

  initial begin
    bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_lines = '0; bus.ld_data = '0; bus.ld_valid = 1'b0;
    bus.dr_start = 1'b0; bus.dr_base = '0; bus.dr_lines = '0; bus.dr_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) omem[a] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_load_coin();
    test_load_gaps();
    test_drain();
    test_drain_backpressure();
    test_wrap_zero();
    test_concurrent();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kyber_host_bram_bridge.md
Name: kyber_host_bram_bridge

Overview:
- Host-side counterpart to the Kyber core's BRAM engine. Converts a 32-bit word stream into 128-bit line writes on the input BRAM (host→core), and 128-bit line reads from the output BRAM (core→host) back into a 32-bit word stream.
- Sits between the register/DMA front end and the two true-dual-port BRAMs. It drives the ports opposite the core's read and write ports.
- Load and drain channels are fully independent and may run concurrently.

Parameters:
- ADDR_W, 8, BRAM line address width; addresses wrap mod 2^ADDR_W.
- LINE_W, 128, BRAM data width.
- WORD_W, 32, stream word width; LANES = LINE_W/WORD_W = 4.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2).

Ports:
- reg_clk  in  1  sole clock.
- reg_rst_n  in  1  asynchronous, active-low reset.
- ld_start  in  1  one-cycle pulse; latches ld_base and ld_lines.
- ld_base  in  ADDR_W  first line address for the load.
- ld_lines  in  ADDR_W  number of lines to load.
- ld_data  in  WORD_W  stream word.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  bridge accepts ld_data.
- ld_done  out  1  one-cycle pulse when the load completes.
- addr_wr  out  ADDR_W  input-BRAM write address.
- en_wr  out  1  input-BRAM enable.
- we_wr  out  LINE_W/8  input-BRAM byte write enables.
- wrdata_wr  out  LINE_W  input-BRAM write data.
- dr_start  in  1  one-cycle pulse; latches dr_base and dr_lines.
- dr_base  in  ADDR_W  first line address for the drain.
- dr_lines  in  ADDR_W  number of lines to drain.
- dr_data  out  WORD_W  stream word.
- dr_valid  out  1  dr_data is valid.
- dr_ready  in  1  consumer accepts dr_data.
- dr_done  out  1  one-cycle pulse when the drain completes.
- addr_rd  out  ADDR_W  output-BRAM read address.
- en_rd  out  1  output-BRAM enable.
- rddata_rd  in  LINE_W  output-BRAM read data.

Behaviour:
- Reset (reg_rst_n low, asynchronous):
  - Both FSMs go to IDLE.
  - Every output is 0, including ld_ready, dr_valid, en/we and both done pulses.
  - Reset mid-operation abandons the transfer with no further BRAM writes and no done pulse.
- Lane order: the first word of each line occupies bits [31:0], the fourth occupies [127:96]. This matches the core's [0 +: 32] low-lane convention.
- Load FSM: L_IDLE → L_FILL → L_IDLE.
  - In L_IDLE, ld_start latches base/lines. If lines==0, ld_done pulses next cycle and the FSM stays in L_IDLE. Otherwise it enters L_FILL with lane=0, line=0.
  - In L_FILL, ld_ready=1. Each cycle with ld_valid&ld_ready stores the word into lane[lane] and increments lane.
  - On acceptance of lane 3, the next cycle presents addr_wr=base+line (mod 2^ADDR_W), wrdata_wr=packed line, en_wr=1, we_wr=all-ones, for exactly one cycle. In all other cycles en_wr=0 and we_wr=0.
  - Throughput is 1 word/cycle with no bubble between lines.
  - After the final line's write cycle, ld_done pulses on the following cycle and the FSM returns to L_IDLE. ld_ready drops the cycle after the last word is accepted.
- Drain FSM: D_IDLE → D_REQ → D_WAIT → D_EMIT → (D_REQ | D_IDLE).
  - In D_IDLE, dr_start latches base/lines. If lines==0, dr_done pulses next cycle.
  - D_REQ lasts one cycle: en_rd=1, addr_rd=base+line.
  - D_WAIT lasts RD_LAT cycles. On its last cycle rddata_rd is captured into the line buffer.
  - D_EMIT: dr_valid=1 and dr_data=buffer lane[lane]. dr_data is held stable until dr_ready. Each handshake advances lane.
  - After lane 3 handshakes, line increments. If lines remain, the FSM enters D_REQ; otherwise dr_done pulses the next cycle and the FSM returns to D_IDLE.
  - Latency: the first dr_valid rises 2+RD_LAT cycles after dr_start. Each subsequent line adds 1+RD_LAT bubble cycles.
  - dr_ready held low stalls indefinitely with data stable and no extra BRAM reads.
- Start pulses arriving while the corresponding FSM is not in IDLE are ignored, and base/lines stay unchanged.
- ld_start and dr_start in the same cycle are both honoured.
- Address arithmetic: base+line truncates to ADDR_W. Example: base=255, lines=2 writes lines 255 then 0.
- Words presented with ld_valid outside L_FILL are not consumed.

Decomposition:
- Package kyber_bram_pkg:
  - line offsets: PK_OFF=0, M_OFF=50, COIN_OFF=52, SK_OFF=54, C_OFF=102.
  - line counts: PK_LINES=50, M_LINES=2, COIN_LINES=2, SK_LINES=48, C_LINES=48.
  - LANES=4.
  - load_state_t and drain_state_t enums.
- Sub-module kyber_bram_drain holds the drain FSM and line buffer. The load path stays in the top module.

Test Plan:
- Load coin: ld_start base=52 lines=2, 8 back-to-back words 0x0..0x7. Expect:
  - a write at addr 52, data 0x00000003_00000002_00000001_00000000;
  - a write at addr 53 with words 4..7;
  - exactly 2 en_wr pulses, then ld_done one cycle after the second.
- Load with random ld_valid gaps, pk_in base=0 lines=50, 200 words. Expect 50 writes at addrs 0..49 with correct packing, and one ld_done.
- Drain, dr_ready held high, base=102 lines=2, RD_LAT=1, BRAM preloaded. Expect:
  - first dr_valid 3 cycles after dr_start;
  - 8 words in lane order;
  - exactly 2 en_rd pulses, at addrs 102 and 103;
  - dr_done after the 8th handshake.
- Drain backpressure: dr_ready low for 10 cycles mid-line. Expect dr_data stable and no en_rd during the stall.
- Wrap and zero length:
  - ld base=255 lines=2 writes addrs 255 then 0.
  - ld_lines=0 gives ld_done one cycle after ld_start with no en_wr.
- Reset mid-load: assert reg_rst_n=0 after 5 of 8 words. Expect all outputs 0 immediately, no further writes and no ld_done. A new ld_start then works normally.
